alu_arbiter: RTL and testbench

// Shares one combinational ALU between two requesters (r0, r1) with round-robin arbitration.

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, single-entry result slot.
// Latency: result is valid the cycle after the requester's ready.
// Backpressure: when the slot is full and rsp_ready is low, no request is accepted and the response holds.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [3:0]       r0_op,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [3:0]       r1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
  } req_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             grant;
  logic             accept;
  req_t             req_sel;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;

  always_comb begin
    if (r0_valid && r1_valid) grant = ~last_grant_q;
    else                      grant = r1_valid;
  end

  // Gated by rst_n so neither requester sees ready while reset is asserted.
  assign accept   = rst_n && (r0_valid || r1_valid) && ((state_q == EMPTY) || rsp_ready);
  assign r0_ready = accept && !grant;
  assign r1_ready = accept && grant;

  always_comb begin
    req_sel = grant ? '{a: r1_a, b: r1_b, op: r1_op} : '{a: r0_a, b: r0_b, op: r0_op};
  end

  assign shamt = req_sel.b[4:0];

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (req_sel.op)
      4'b0000: alu_res = req_sel.a + req_sel.b;
      4'b1000: alu_res = req_sel.a - req_sel.b;
      4'b0001: alu_res = req_sel.a << shamt;
      4'b0010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(req_sel.a) < $signed(req_sel.b))};
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, (req_sel.a < req_sel.b)};
      4'b0100: alu_res = req_sel.a ^ req_sel.b;
      4'b0101: alu_res = req_sel.a >> shamt;
      4'b1101: alu_res = $unsigned($signed(req_sel.a) >>> shamt);
      4'b0110: alu_res = req_sel.a | req_sel.b;
      4'b0111: alu_res = req_sel.a & req_sel.b;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    stall_cnt_d  = stall_cnt_q;

    if ((state_q == FULL) && !rsp_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    if (accept) begin
      state_d      = FULL;
      last_grant_d = grant;
      rsp_id_d     = grant;
      rsp_data_d   = alu_res;
      rsp_err_d    = alu_err;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, arbitration, backpressure, op coverage, error ops, mid-run reset.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0_valid, r0_ready;
  logic [31:0] r0_a, r0_b;
  logic [3:0]  r0_op;
  logic        r1_valid, r1_ready;
  logic [31:0] r1_a, r1_b;
  logic [3:0]  r1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                     input logic [31:0] exp_data, input logic exp_err, input string tag);
    r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op;
    #1;
    chk({tag, "_r0_ready"}, 32'(r0_ready), 32'd1);
    tick();
    chk({tag, "_data"}, rsp_data, exp_data);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  logic exp_g;

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd2; r0_op = 4'b0000;
    r1_valid = 1'b1; r1_a = '0; r1_b = '0; r1_op = 4'b0000;
    #12;
    chk("rst_r0_ready", 32'(r0_ready), 32'd0);
    chk("rst_r1_ready", 32'(r1_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);

    // Single request from r0: 1+2.
    r1_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("t1_r0_ready", 32'(r0_ready), 32'd1);
    chk("t1_r1_ready", 32'(r1_ready), 32'd0);
    tick();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_id", 32'(rsp_id), 32'd0);
    chk("t1_data", rsp_data, 32'd3);
    chk("t1_err", 32'(rsp_err), 32'd0);
    r0_valid = 1'b0;
    tick();
    chk("t1_drain", 32'(rsp_valid), 32'd0);

    // Contention: r0 won last, so r1 goes first, then alternate.
    r0_valid = 1'b1; r0_a = 32'd10; r0_b = 32'd5; r0_op = 4'b0000;
    r1_valid = 1'b1; r1_a = 32'd10; r1_b = 32'd5; r1_op = 4'b1000;
    exp_g = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_r0_ready", 32'(r0_ready), 32'(!exp_g));
      chk("rr_r1_ready", 32'(r1_ready), 32'(exp_g));
      tick();
      chk("rr_id", 32'(rsp_id), 32'(exp_g));
      chk("rr_data", rsp_data, exp_g ? 32'd5 : 32'd15);
      exp_g = ~exp_g;
    end

    // Backpressure: slot holds r0's 15 while r1 waits.
    r0_valid = 1'b0; rsp_ready = 1'b0;
    r1_a = 32'd7; r1_b = 32'd3; r1_op = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_r1_ready", 32'(r1_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_data", rsp_data, 32'd15);
    end
    chk("bp_stall", 32'(stall_cnt), 32'd3);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(r1_ready), 32'd1);
    tick();
    chk("bp_release_id", 32'(rsp_id), 32'd1);
    chk("bp_release_data", rsp_data, 32'd4);
    chk("bp_stall_hold", 32'(stall_cnt), 32'd3);
    r1_valid = 1'b0;

    // Op coverage through r0.
    op0(32'd4,          32'd2,  4'b1000, 32'd2,          1'b0, "sub");
    op0(32'd3,          32'd2,  4'b0010, 32'd0,          1'b0, "slt");
    op0(32'hFFFF_FFFF,  32'd1,  4'b0010, 32'd1,          1'b0, "slt_neg");
    op0(32'hFFFF_FFFF,  32'd1,  4'b0011, 32'd0,          1'b0, "sltu");
    op0(32'h8000_0000,  32'd4,  4'b1101, 32'hF800_0000, 1'b0, "sra");
    op0(32'h8000_0000,  32'd4,  4'b0101, 32'h0800_0000, 1'b0, "srl_msb");
    op0(32'h20,         32'd5,  4'b0101, 32'd1,          1'b0, "srl");
    op0(32'd1,          32'd33, 4'b0001, 32'd2,          1'b0, "sll");
    op0(32'hFFFF_FFFF,  32'd1,  4'b0000, 32'd0,          1'b0, "add_wrap");
    op0(32'hF0,         32'h0F, 4'b0110, 32'hFF,         1'b0, "or");
    op0(32'hFF,         32'h0F, 4'b0111, 32'h0F,         1'b0, "and");
    op0(32'hFF,         32'h0F, 4'b0100, 32'hF0,         1'b0, "xor");
    op0(32'd5,          32'd5,  4'b1001, 32'd0,          1'b1, "illegal");
    op0(32'd1,          32'd1,  4'b0000, 32'd2,          1'b0, "after_err");
    op0(32'd9,          32'd9,  4'b1111, 32'd0,          1'b1, "illegal2");
    chk("err_id", 32'(rsp_id), 32'd0);

    // Asynchronous reset while FULL.
    r0_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    chk("arst_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    r0_valid = 1'b1; r0_a = 32'd2; r0_b = 32'd2; r0_op = 4'b0000;
    r1_valid = 1'b1; r1_a = 32'd8; r1_b = 32'd1; r1_op = 4'b0000;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_r0_ready", 32'(r0_ready), 32'd1);
    chk("post_rst_r1_ready", 32'(r1_ready), 32'd0);
    tick();
    chk("post_rst_id", 32'(rsp_id), 32'd0);
    chk("post_rst_data", rsp_data, 32'd4);
    #1;
    chk("post_rst_next_r1", 32'(r1_ready), 32'd1);
    tick();
    chk("post_rst_next_id", 32'(rsp_id), 32'd1);
    chk("post_rst_next_data", rsp_data, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
